aes_round_sched: RTL and testbench
==================================

Name: aes_round_sched

Overview:
- Iterative AES round sequencer: controls the shared registered round datapath (SubBytes -> ShiftRows -> MixColumns -> AddRoundKey) for one 128-bit block at a time.
- Accepts a start handshake, issues the initial AddRoundKey load, then for each round requests a round key, enables the datapath for its pipeline latency and flags the final round (MixColumns bypass).
- Signals completion with a valid/ready handshake.
- Sits between the top-level AES wrapper and the round datapath / key-expansion blocks.

Parameters:
NR, 10, number of rounds (legal 1..14; 10 for AES-128)
DP_LAT, 3, registered pipeline depth of one datapath round in cycles (legal 1..15)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  reset, asynchronous, active-low
start_valid  in  1  requester has a block (plaintext and key presented externally)
start_ready  out  1  sequencer idle, can accept a block
load_init  out  1  one-cycle strobe: datapath state register <= plaintext XOR key (round 0)
rk_req  out  1  round-key request to key expansion
rk_round  out  4  round index of requested key (valid while rk_req)
rk_ack  in  1  round key available this cycle
dp_en  out  1  datapath pipeline stage enable
round_num  out  4  current round index
final_round  out  1  high during RUN of round NR: datapath bypasses MixColumns
busy  out  1  high in any state other than IDLE
done_valid  out  1  ciphertext valid on datapath output
done_ready  in  1  consumer accepts ciphertext

Behaviour:
- One clock (clk); reset is asynchronous and active-low (rst_n). All outputs are Moore decodes of registered state/counters.
- Reset (any time, including mid-block): state=IDLE, round_num=0, lat_cnt=0. Outputs: start_ready=1; all others 0; rk_round=0. In-flight block discarded, no done_valid.
- States: IDLE, INIT, KEYREQ, RUN, DONE.
- IDLE: start_ready=1. On start_valid=1 -> INIT, round_num<=0. start_valid ignored in every other state.
- INIT (1 cycle): load_init=1 -> KEYREQ, round_num<=1.
- KEYREQ: rk_req=1, rk_round=round_num.
  - Holds until rk_ack=1 is sampled, then -> RUN, lat_cnt<=0.
  - rk_ack outside KEYREQ is ignored.
- RUN: dp_en=1 every cycle; lat_cnt increments. When lat_cnt==DP_LAT-1:
  - if round_num==NR -> DONE
  - else round_num<=round_num+1 -> KEYREQ
  - final_round = (round_num==NR) in RUN only.
- DONE: done_valid=1 and stays high until done_ready=1 is sampled -> IDLE, round_num<=0. dp_en=0 in DONE, so datapath output is held stable.
- Latency with rk_ack tied 1, start accepted at cycle T:
  - load_init at T+1.
  - Round k: rk_req at T+2+(k-1)(DP_LAT+1); RUN for the following DP_LAT cycles.
  - done_valid first high at T+2+NR*(DP_LAT+1). Defaults: T+42.
- Counters: round_num is 4-bit and never exceeds NR, so no wrap. lat_cnt is 4-bit.
- Back-to-back: new start is accepted only after IDLE is re-entered, i.e. the cycle after the done_valid/done_ready transfer. start_valid held high is accepted on that cycle.

Optional Feature:
AES_SCHED_ABORT_EN:
- Defined: adds input abort (1 bit). abort=1 sampled in INIT/KEYREQ/RUN/DONE -> IDLE next cycle, round_num<=0, all strobes low. No done_valid is produced for the aborted block. abort in IDLE: no effect; takes priority over start_valid in IDLE? No: in IDLE start is accepted normally. In DONE, abort wins over done_ready; both lead to IDLE.
- Undefined: no abort port; block always runs to DONE.

Test Plan:
- Reset mid-RUN (round 4), rst_n low 1 cycle -> asynchronously start_ready=1, busy=0, dp_en=0, round_num=0; no done_valid afterwards.
- rk_ack=1, done_ready=1 constant, start at T, defaults -> load_init at T+1 only; rk_round 1..10 at T+2, T+6, ..., T+38; final_round high T+39..T+41 only; done_valid at T+42; start_ready at T+43.
- rk_ack delayed 5 cycles in round 3 -> rk_req/rk_round=3 held 5 cycles, dp_en=0 meanwhile; done_valid shifted by exactly 5 cycles (T+47).
- done_ready low 7 cycles after done_valid -> done_valid and round_num=10 held; dp_en=0; new start_valid ignored until IDLE.
- NR=1, DP_LAT=1 -> load_init at T+1, rk_req at T+2, single RUN cycle with final_round=1 at T+3, done_valid at T+4.
- AES_SCHED_ABORT_EN: abort in round 6 RUN -> IDLE next cycle, no done_valid; next start gives a full-length sequence.

Source files
------------

// File: rtl/aes_round_sched.sv
// aes_round_sched
// ----------------
// Iterative AES round sequencer. It steers one shared registered round
// datapath (SubBytes -> ShiftRows -> MixColumns -> AddRoundKey) through a
// complete block encryption. The sequence for each block is:
//   1. Accept a block on the start handshake.
//   2. Pulse load_init for the round-0 AddRoundKey.
//   3. For each round 1..NR, request the round key and then enable the
//      datapath for DP_LAT cycles.
//   4. Present the result on the done handshake.
//
// Parameters:
//   NR      number of rounds (1..14, 10 for AES-128)
//   DP_LAT  registered depth of one datapath round in cycles (1..15)
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   start_valid/start_ready  block request handshake (ready == idle)
//   load_init                one-cycle strobe: state <= plaintext ^ key
//   rk_req/rk_round/rk_ack   round-key request to key expansion
//   dp_en                    datapath stage enable
//   round_num                current round index
//   final_round              last round: datapath bypasses MixColumns
//   busy                     sequencer not idle
//   done_valid/done_ready    ciphertext handshake
//   abort                    (only with AES_SCHED_ABORT_EN defined) drop
//                            the in-flight block and return to idle
//
// Optional feature macro: AES_SCHED_ABORT_EN.
// All outputs are Moore decodes of the registered state and counters.

module aes_round_sched #(
    parameter int NR     = 10,
    parameter int DP_LAT = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_valid,
    output logic       start_ready,
    output logic       load_init,
    output logic       rk_req,
    output logic [3:0] rk_round,
    input  logic       rk_ack,
    output logic       dp_en,
    output logic [3:0] round_num,
    output logic       final_round,
    output logic       busy,
    output logic       done_valid,
    input  logic       done_ready
`ifdef AES_SCHED_ABORT_EN
    ,
    input  logic       abort
`endif
);

    localparam logic [3:0] NR_L     = 4'(NR);
    localparam logic [3:0] LAT_LAST = 4'(DP_LAT - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_INIT   = 3'd1,
        ST_KEYREQ = 3'd2,
        ST_RUN    = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t     state_reg, state_next;
    logic [3:0] round_reg, round_next;
    logic [3:0] lat_cnt_reg, lat_cnt_next;
    logic       abort_req;

`ifdef AES_SCHED_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            round_reg   <= 4'd0;
            lat_cnt_reg <= 4'd0;
        end else begin
            state_reg   <= state_next;
            round_reg   <= round_next;
            lat_cnt_reg <= lat_cnt_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        round_next   = round_reg;
        lat_cnt_next = lat_cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start_valid) begin
                    state_next = ST_INIT;
                    round_next = 4'd0;
                end
            end
            ST_INIT: begin
                state_next = ST_KEYREQ;
                round_next = 4'd1;
            end
            ST_KEYREQ: begin
                if (rk_ack) begin
                    state_next   = ST_RUN;
                    lat_cnt_next = 4'd0;
                end
            end
            ST_RUN: begin
                if (lat_cnt_reg == LAT_LAST) begin
                    lat_cnt_next = 4'd0;
                    if (round_reg == NR_L) begin
                        state_next = ST_DONE;
                    end else begin
                        round_next = round_reg + 4'd1;
                        state_next = ST_KEYREQ;
                    end
                end else begin
                    lat_cnt_next = lat_cnt_reg + 4'd1;
                end
            end
            ST_DONE: begin
                // Datapath is frozen here (dp_en low) so the result holds.
                if (done_ready) begin
                    state_next = ST_IDLE;
                    round_next = 4'd0;
                end
            end
            default: begin
                state_next   = ST_IDLE;
                round_next   = 4'd0;
                lat_cnt_next = 4'd0;
            end
        endcase

        // Abort overrides every busy-state transition, including a
        // simultaneous done_ready in DONE. It has no effect in IDLE.
        if (abort_req && (state_reg != ST_IDLE)) begin
            state_next   = ST_IDLE;
            round_next   = 4'd0;
            lat_cnt_next = 4'd0;
        end
    end

    assign start_ready = (state_reg == ST_IDLE);
    assign load_init   = (state_reg == ST_INIT);
    assign rk_req      = (state_reg == ST_KEYREQ);
    assign rk_round    = (state_reg == ST_KEYREQ) ? round_reg : 4'd0;
    assign dp_en       = (state_reg == ST_RUN);
    assign round_num   = round_reg;
    assign final_round = (state_reg == ST_RUN) && (round_reg == NR_L);
    assign busy        = (state_reg != ST_IDLE);
    assign done_valid  = (state_reg == ST_DONE);

endmodule

// File: tb/tb_aes_round_sched.sv
// Testbench for aes_round_sched. Instance a uses the default parameters
// (NR=10, DP_LAT=3); instance b uses NR=1, DP_LAT=1. Stimulus pushes the
// expected event trace of each block into a queue. A monitor samples both
// instances on the falling edge and pops and compares one event per
// observed transaction. The observed transactions are start accept,
// load_init, key transfer, each dp_en cycle and the done transfer.

module tb_aes_round_sched;

    typedef struct {
        int inst;
        int kind;
        int cyc;
        int rnd;
        int fin;
    } ev_t;

    localparam int K_START = 0, K_LOAD = 1, K_KEY = 2, K_RUN = 3, K_DONE = 4;

    logic clk, rst_n;
    int   cyc = 0;
    int   tests = 0, fails = 0;
    bit   mon_en = 1'b1;
    ev_t  exp_q[$];

    // responder configuration for instance a
    int dr_cfg = 0, dd_cfg = 0, dw_cfg = 0;

    logic       start_valid_a, start_ready_a, load_init_a, rk_req_a, rk_ack_a;
    logic [3:0] rk_round_a, round_num_a;
    logic       dp_en_a, final_round_a, busy_a, done_valid_a, done_ready_a;
    logic       start_valid_b, start_ready_b, load_init_b, rk_req_b, rk_ack_b;
    logic [3:0] rk_round_b, round_num_b;
    logic       dp_en_b, final_round_b, busy_b, done_valid_b, done_ready_b;
`ifdef AES_SCHED_ABORT_EN
    logic       abort_a, abort_b;
`endif

    aes_round_sched dut_a (
        .clk(clk), .rst_n(rst_n),
        .start_valid(start_valid_a), .start_ready(start_ready_a),
        .load_init(load_init_a), .rk_req(rk_req_a), .rk_round(rk_round_a),
        .rk_ack(rk_ack_a), .dp_en(dp_en_a), .round_num(round_num_a),
        .final_round(final_round_a), .busy(busy_a),
        .done_valid(done_valid_a), .done_ready(done_ready_a)
`ifdef AES_SCHED_ABORT_EN
        , .abort(abort_a)
`endif
    );

    aes_round_sched #(.NR(1), .DP_LAT(1)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .start_valid(start_valid_b), .start_ready(start_ready_b),
        .load_init(load_init_b), .rk_req(rk_req_b), .rk_round(rk_round_b),
        .rk_ack(rk_ack_b), .dp_en(dp_en_b), .round_num(round_num_b),
        .final_round(final_round_b), .busy(busy_b),
        .done_valid(done_valid_b), .done_ready(done_ready_b)
`ifdef AES_SCHED_ABORT_EN
        , .abort(abort_b)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kname(input int k);
        case (k)
            K_START: return "START";
            K_LOAD:  return "LOAD";
            K_KEY:   return "KEY";
            K_RUN:   return "RUN";
            default: return "DONE";
        endcase
    endfunction

    task automatic push(input int inst, input int kind, input int c, input int rnd, input int fin);
        ev_t e;
        e.inst = inst; e.kind = kind; e.cyc = c; e.rnd = rnd; e.fin = fin;
        exp_q.push_back(e);
    endtask

    // Expected trace for one block accepted at cycle t: round dr waits dd
    // extra cycles for its key, the consumer stalls dw cycles on done.
    task automatic exp_block(input int inst, input int t, input int nr, input int lat,
                             input int dr, input int dd, input int dw, output int t_done);
        int kr, ack;
        push(inst, K_START, t, 0, 0);
        push(inst, K_LOAD, t + 1, 0, 0);
        kr = t + 2;
        for (int k = 1; k <= nr; k++) begin
            ack = kr + ((k == dr) ? dd : 0);
            push(inst, K_KEY, ack, k, 0);
            for (int j = 1; j <= lat; j++) push(inst, K_RUN, ack + j, k, (k == nr) ? 1 : 0);
            kr = ack + lat + 1;
        end
        t_done = kr + dw;
        push(inst, K_DONE, t_done, nr, 0);
    endtask

    task automatic got(input int inst, input int kind, input int rnd, input int fin);
        ev_t e;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("[TB] FAIL unexpected: inst%0d %s cyc %0d rnd %0d fin %0d, expected no event",
                     inst, kname(kind), cyc, rnd, fin);
        end else begin
            e = exp_q.pop_front();
            if (e.inst != inst || e.kind != kind || e.cyc != cyc || e.rnd != rnd || e.fin != fin) begin
                fails++;
                $display("[TB] FAIL event: got inst%0d %s cyc %0d rnd %0d fin %0d, expected inst%0d %s cyc %0d rnd %0d fin %0d",
                         inst, kname(kind), cyc, rnd, fin, e.inst, kname(e.kind), e.cyc, e.rnd, e.fin);
            end else begin
                $display("[TB] inst%0d %s cyc %0d rnd %0d fin %0d ok", inst, kname(kind), cyc, rnd, fin);
            end
        end
    endtask

    task automatic sample_inst(input int inst, input logic sv, input logic sr, input logic li,
                               input logic rq, input logic ra, input logic [3:0] rr,
                               input logic de, input logic [3:0] rn, input logic fr,
                               input logic dv, input logic dy);
        if (sv && sr) got(inst, K_START, 0, 0);
        if (li)       got(inst, K_LOAD, int'(rn), 0);
        if (rq && ra) got(inst, K_KEY, int'(rr), 0);
        if (de)       got(inst, K_RUN, int'(rn), int'(fr));
        if (dv && dy) got(inst, K_DONE, int'(rn), 0);
    endtask

    // Monitor
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                sample_inst(0, start_valid_a, start_ready_a, load_init_a, rk_req_a, rk_ack_a,
                            rk_round_a, dp_en_a, round_num_a, final_round_a, done_valid_a, done_ready_a);
                sample_inst(1, start_valid_b, start_ready_b, load_init_b, rk_req_b, rk_ack_b,
                            rk_round_b, dp_en_b, round_num_b, final_round_b, done_valid_b, done_ready_b);
            end
        end
    end

    // Key-expansion and consumer responders for instance a. rk_ack is held
    // high outside KEYREQ so that stray acks are exercised.
    initial begin
        int ack_cnt, dcnt;
        ack_cnt = 0; dcnt = 0;
        rk_ack_a = 1'b0; done_ready_a = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (rk_req_a) begin
                rk_ack_a = (int'(rk_round_a) != dr_cfg) || (ack_cnt >= dd_cfg);
                ack_cnt++;
            end else begin
                rk_ack_a = 1'b1;
                ack_cnt  = 0;
            end
            if (done_valid_a) begin
                done_ready_a = (dcnt >= dw_cfg);
                dcnt++;
            end else begin
                done_ready_a = 1'b0;
                dcnt = 0;
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp_v);
        tests++;
        if (act != exp_v) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", nm, act, exp_v);
        end else begin
            $display("[TB] check %s ok (%0d)", nm, act);
        end
    endtask

    task automatic at_cycle(input int c);
        while (cyc < c) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!((busy_a == 1'b0) && (busy_b == 1'b0) && (exp_q.size() == 0)) && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 400) begin
            tests++; fails++;
            $display("[TB] FAIL wait_idle timeout: %0d events pending, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic wait_round_run(input int r);
        int n;
        n = 0;
        while (!(dp_en_a && int'(round_num_a) == r) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("reach_round_run", (n < 200) ? r : -1, r);
    endtask

    task automatic pulse_start_a(output int t);
        start_valid_a = 1'b1;
        t = cyc;
    endtask

    initial begin
        int t, td, tb2;
        rst_n = 1'b0;
        start_valid_a = 1'b0; start_valid_b = 1'b0;
        rk_ack_b = 1'b1; done_ready_b = 1'b1;
`ifdef AES_SCHED_ABORT_EN
        abort_a = 1'b0; abort_b = 1'b0;
`endif
        #1;
        chk("rst_start_ready", int'(start_ready_a), 1);
        chk("rst_busy", int'(busy_a), 0);
        chk("rst_rk_round", int'(rk_round_a), 0);
        chk("rst_outs_zero", int'({load_init_a, rk_req_a, dp_en_a, final_round_a, done_valid_a}), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Nominal block, defaults: done at T+42.
        dr_cfg = 0; dd_cfg = 0; dw_cfg = 0;
        pulse_start_a(t);
        exp_block(0, t, 10, 3, 0, 0, 0, td);
        @(posedge clk); #1 start_valid_a = 1'b0;
        wait_idle();

        // Round-3 key delayed 5 cycles: done at T+47.
        dr_cfg = 3; dd_cfg = 5;
        pulse_start_a(t);
        exp_block(0, t, 10, 3, 3, 5, 0, td);
        @(posedge clk); #1 start_valid_a = 1'b0;
        wait_idle();
        dr_cfg = 0; dd_cfg = 0;

        // Consumer stalls 7 cycles. start_valid stays high throughout and is
        // only taken once IDLE is re-entered.
        dw_cfg = 7;
        pulse_start_a(t);
        exp_block(0, t, 10, 3, 0, 0, 7, td);
        at_cycle(t + 45);
        chk("done_hold_valid", int'(done_valid_a), 1);
        chk("done_hold_round", int'(round_num_a), 10);
        chk("done_hold_dp_en", int'(dp_en_a), 0);
        chk("done_hold_start_ready", int'(start_ready_a), 0);
        at_cycle(td + 1);
        dw_cfg = 0;
        exp_block(0, td + 1, 10, 3, 0, 0, 0, tb2);
        at_cycle(td + 2);
        start_valid_a = 1'b0;
        wait_idle();

        // NR=1, DP_LAT=1 instance: done at T+4.
        start_valid_b = 1'b1;
        exp_block(1, cyc, 1, 1, 0, 0, 0, td);
        @(posedge clk); #1 start_valid_b = 1'b0;
        wait_idle();

        // Asynchronous reset in the middle of round 4.
        mon_en = 1'b0;
        pulse_start_a(t);
        @(posedge clk); #1 start_valid_a = 1'b0;
        wait_round_run(4);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_start_ready", int'(start_ready_a), 1);
        chk("arst_busy", int'(busy_a), 0);
        chk("arst_dp_en", int'(dp_en_a), 0);
        chk("arst_round_num", int'(round_num_a), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        mon_en = 1'b1;
        repeat (60) @(posedge clk);
        #1 chk("arst_stays_idle", int'(busy_a), 0);

`ifdef AES_SCHED_ABORT_EN
        // Abort during round 6 RUN, then a full-length block.
        mon_en = 1'b0;
        pulse_start_a(t);
        @(posedge clk); #1 start_valid_a = 1'b0;
        wait_round_run(6);
        abort_a = 1'b1;
        @(posedge clk); #1 abort_a = 1'b0;
        chk("abort_busy", int'(busy_a), 0);
        chk("abort_dp_en", int'(dp_en_a), 0);
        chk("abort_round_num", int'(round_num_a), 0);
        mon_en = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        pulse_start_a(t);
        exp_block(0, t, 10, 3, 0, 0, 0, td);
        @(posedge clk); #1 start_valid_a = 1'b0;
        wait_idle();
`endif

        chk("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
